sdram_read: RTL and testbench
=============================

// Module: sdram_read
// PURPOSE
//  SDRAM burst-read engine; the read-side counterpart of sdram_write, under the SDRAM arbiter.
//  On an accepted request, issues ACTIVE -> READ (full-page) -> BURST_STOP -> PRECHARGE,
//  captures rd_burst_len words from DQ and presents them with a valid strobe for the read FIFO.
//  Command/bank/address outputs go to the arbiter mux; rd_end returns bus ownership.
// PARAMETERS
//  TRCD_CLK  2  NOP cycles between ACTIVE and READ (>=1)
//  TRP_CLK   2  NOP cycles after PRECHARGE before rd_end (>=1)
//  CL_CLK    3  CAS latency in clocks, must match init mode register (2 or 3)
// PORTS
//  sys_clk        in   1   system clock, all logic on rising edge
//  sys_rst        in   1   synchronous reset, active-high
//  init_end       in   1   SDRAM initialisation complete
//  rd_en          in   1   read request from arbiter, level, held until rd_ack
//  addr           in   24  {bank[23:22], row[21:9], col[8:0]}, sampled on acceptance
//  rd_burst_len   in   10  words to read, sampled on acceptance
//  rd_sdram_data  in   16  DQ read data from pad register
//  rd_ack         out  1   1-cycle pulse: request accepted
//  rd_cmd         out  4   {cs_n,ras_n,cas_n,we_n}
//  rd_ba          out  2   bank address
//  rd_addr        out  13  SDRAM A[12:0]
//  rd_data        out  16  captured read word
//  rd_data_vld    out  1   rd_data valid this cycle
//  rd_end         out  1   1-cycle pulse: burst and precharge complete
// BEHAVIOUR
//  Commands: NOP 4'b0111, ACTIVE 4'b0011, READ 4'b0101, BST 4'b0110, PRECHARGE 4'b0010.
//  Reset: state IDLE, rd_cmd=NOP, rd_ba=2'b11, rd_addr=13'h1FFF, rd_data=0, rd_ack=0,
//   rd_data_vld=0, rd_end=0, counters 0. Reset mid-burst aborts at once (no BST/PRE issued).
//  rd_cmd/rd_ba/rd_addr are decoded from the current state; idle value = reset value.
//  IDLE: rd_en & init_end -> latch addr, len -> ACTIVE. rd_en without init_end is ignored.
//  Length rule: len=0 is treated as 1; len>512 is clamped to 512 (one row, no row crossing).
//  ACTIVE (1 cyc): cmd ACTIVE, ba=bank, A=row, rd_ack=1 -> TRCD.
//  TRCD (TRCD_CLK cyc): NOP -> READ.
//  READ (1 cyc): cmd READ, ba=bank, A={4'b0000,col} (A10=0, no auto-precharge) -> DATA.
//  DATA: cnt=1 on the first cycle after READ, +1 per cycle.
//   - cnt==len: cmd BST (ba/A hold); otherwise NOP.
//   - Word k (0..len-1) is on rd_sdram_data when cnt==CL_CLK+k. It is registered, so
//     rd_data=word k and rd_data_vld=1 on the next cycle. Exactly len vld pulses, contiguous.
//   - cnt==CL_CLK+len-1 -> PRE.
//  Column wraps 511->0 inside the row (SDRAM full-page behaviour); no special handling.
//  PRE (1 cyc): cmd PRECHARGE, A10=1 (all banks) -> TRP. Last vld pulse coincides with PRE.
//  TRP (TRP_CLK cyc): NOP -> END.
//  END (1 cyc): rd_end=1 -> IDLE. rd_en during END is not accepted; it is accepted in IDLE the
//   next cycle. Minimum gap rd_end -> next rd_ack is 2 cycles.
//  init_end falling mid-burst is ignored; the burst completes.
//  addr/rd_burst_len changes after acceptance have no effect.
//  Counters: cnt is 11 bits; TRCD/TRP/CL counters are sized from the parameters.
// TESTING
//  1 Reset: hold sys_rst 3 cyc with rd_en=1 -> outputs at reset values, no rd_ack.
//  2 Default params, addr=24'h40_0203, len=4, rd_en at cyc0 -> ACTIVE cyc1 (ba=1, A=1);
//    READ cyc4 (A=3); BST cyc8; vld cyc8..11; PRECHARGE cyc11 (A=13'h0400);
//    rd_end cyc14; IDLE cyc15.
//  3 len=0 -> one vld pulse; len=700 -> 512 vld pulses; col=510, len=4 -> data order
//    follows columns 510,511,0,1.
//  4 rd_en=1, init_end=0 for 10 cyc -> only NOP; raising init_end -> rd_ack next cycle.
//  5 rd_en held through rd_end with a new addr -> second rd_ack 2 cyc after rd_end;
//    second burst uses the new addr.
//  6 sys_rst pulse at cnt==2 of a len=8 burst -> next cycle IDLE, NOP, vld=0, no rd_end;
//    a new request afterwards completes normally.

Source files
------------

// File: rtl/sdram_read.sv
// sdram_read: SDRAM full-page burst-read engine (ACTIVE -> READ -> BST -> PRECHARGE)
//  sys_clk/sys_rst   clock, synchronous active-high reset
//  init_end          SDRAM initialisation complete, gates request acceptance
//  rd_en/rd_ack      level request from arbiter / 1-cycle accept pulse
//  addr/rd_burst_len {bank,row,col} and word count, sampled on acceptance
//  rd_sdram_data     DQ from pad register
//  rd_cmd/ba/addr    command bus to arbiter mux, decoded from state
//  rd_data/_vld      registered read words for the read FIFO
//  rd_end            1-cycle pulse returning bus ownership
module sdram_read #(
  parameter int TRCD_CLK = 2,
  parameter int TRP_CLK  = 2,
  parameter int CL_CLK   = 3
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        init_end,
  input  logic        rd_en,
  input  logic [23:0] addr,
  input  logic [9:0]  rd_burst_len,
  input  logic [15:0] rd_sdram_data,
  output logic        rd_ack,
  output logic [3:0]  rd_cmd,
  output logic [1:0]  rd_ba,
  output logic [12:0] rd_addr,
  output logic [15:0] rd_data,
  output logic        rd_data_vld,
  output logic        rd_end
);
  localparam logic [3:0] NOP = 4'b0111, ACTIVE = 4'b0011, READ = 4'b0101, BST = 4'b0110, PRECHARGE = 4'b0010;
  localparam int WMAX = TRCD_CLK > TRP_CLK ? TRCD_CLK : TRP_CLK;
  localparam int WW = WMAX > 1 ? $clog2(WMAX) : 1;
  localparam logic [10:0] CL = 11'(CL_CLK);
  typedef enum logic [2:0] {IDLE, ACT, TRCD, RD, DATA, PRE, TRP, ENDS} state_t;
  state_t state_q, state_d;
  logic [10:0] cnt_q, cnt_d, last;
  logic [WW-1:0] wait_q, wait_d;
  logic [1:0] bank_q, bank_d;
  logic [12:0] row_q, row_d;
  logic [8:0] col_q, col_d;
  logic [9:0] len_q, len_d;
  logic [15:0] data_q, data_d;
  logic vld_q, vld_d;
  // cycle (in DATA) on which the last word is on DQ
  assign last = CL + {1'b0, len_q} - 11'd1;
  assign rd_data = data_q;
  assign rd_data_vld = vld_q;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wait_q <= '0;
      bank_q <= '0;
      row_q <= '0;
      col_q <= '0;
      len_q <= '0;
      data_q <= '0;
      vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wait_q <= wait_d;
      bank_q <= bank_d;
      row_q <= row_d;
      col_q <= col_d;
      len_q <= len_d;
      data_q <= data_d;
      vld_q <= vld_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    wait_d = '0;
    bank_d = bank_q;
    row_d = row_q;
    col_d = col_q;
    len_d = len_q;
    rd_cmd = NOP;
    rd_ba = 2'b11;
    rd_addr = 13'h1FFF;
    rd_ack = 1'b0;
    rd_end = 1'b0;
    vld_d = state_q == DATA && cnt_q >= CL && cnt_q <= last;
    data_d = vld_d ? rd_sdram_data : data_q;
    case (state_q)
      IDLE: if (rd_en && init_end) begin
        state_d = ACT;
        bank_d = addr[23:22];
        row_d = addr[21:9];
        col_d = addr[8:0];
        // zero means one word; more than a row is clamped to the row
        len_d = rd_burst_len == 10'd0 ? 10'd1 : rd_burst_len > 10'd512 ? 10'd512 : rd_burst_len;
      end
      ACT: begin
        rd_cmd = ACTIVE;
        rd_ba = bank_q;
        rd_addr = row_q;
        rd_ack = 1'b1;
        state_d = TRCD;
      end
      TRCD: if (wait_q == WW'(TRCD_CLK - 1)) state_d = RD; else wait_d = wait_q + 1'b1;
      RD: begin
        rd_cmd = READ;
        rd_ba = bank_q;
        rd_addr = {4'b0000, col_q};
        cnt_d = 11'd1;
        state_d = DATA;
      end
      DATA: begin
        rd_cmd = cnt_q == {1'b0, len_q} ? BST : NOP;
        rd_ba = bank_q;
        rd_addr = {4'b0000, col_q};
        cnt_d = cnt_q + 11'd1;
        if (cnt_q == last) state_d = PRE;
      end
      PRE: begin
        rd_cmd = PRECHARGE;
        rd_ba = bank_q;
        rd_addr = 13'h0400;
        state_d = TRP;
      end
      TRP: if (wait_q == WW'(TRP_CLK - 1)) state_d = ENDS; else wait_d = wait_q + 1'b1;
      ENDS: begin
        rd_end = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sdram_read.sv
// tb_sdram_read: randomized self-checking bench for sdram_read with an SDRAM DQ model
module tb_sdram_read;
  localparam int TRCD = 2, TRP = 2, CL = 3;
  localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD = 4'b0101, C_BST = 4'b0110, C_PRE = 4'b0010;
  logic sys_clk = 1'b0, sys_rst = 1'b1, init_end = 1'b0, rd_en = 1'b0;
  logic [23:0] addr = '0;
  logic [9:0] rd_burst_len = '0;
  logic [15:0] rd_sdram_data = '0;
  logic rd_ack, rd_data_vld, rd_end;
  logic [3:0] rd_cmd;
  logic [1:0] rd_ba;
  logic [12:0] rd_addr;
  logic [15:0] rd_data;
  int errs = 0, checks = 0, cyc = 0;
  logic act_m = 1'b0;
  int st_m = 0, bst_m = 0;
  logic [8:0] c_m = '0;
  logic [1:0] b_m = '0;
  logic [12:0] rows_m [4];
  sdram_read #(.TRCD_CLK(TRCD), .TRP_CLK(TRP), .CL_CLK(CL)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end), .rd_en(rd_en), .addr(addr),
    .rd_burst_len(rd_burst_len), .rd_sdram_data(rd_sdram_data), .rd_ack(rd_ack), .rd_cmd(rd_cmd),
    .rd_ba(rd_ba), .rd_addr(rd_addr), .rd_data(rd_data), .rd_data_vld(rd_data_vld), .rd_end(rd_end)
  );
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  function automatic logic [15:0] memw(input logic [1:0] b, input logic [12:0] r, input logic [8:0] c);
    return {b, r[4:0], c} ^ 16'hA5C3;
  endfunction
  // SDRAM model: word k of a READ appears CL cycles after it; BST ends output CL cycles later
  always @(negedge sys_clk) begin
    if (rd_cmd == C_ACT) begin
      rows_m[rd_ba] = rd_addr;
      act_m = 1'b0;
    end
    if (rd_cmd == C_RD) begin
      act_m = 1'b1;
      st_m = cyc;
      c_m = rd_addr[8:0];
      b_m = rd_ba;
      bst_m = cyc + 100000;
    end
    if (rd_cmd == C_BST) bst_m = cyc;
    rd_sdram_data = (act_m && cyc >= st_m + CL && cyc < bst_m + CL) ?
      memw(b_m, rows_m[b_m], c_m + 9'(cyc - st_m - CL)) : 16'($urandom);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic burst(input logic [1:0] b, input logic [12:0] r, input logic [8:0] c, input int len,
                       input int exp_wait, input bit hold);
    int ln, rr, pe, eo, w, bad, bd, k;
    logic [3:0] ec;
    ln = len == 0 ? 1 : (len > 512 ? 512 : len);
    rr = 1 + TRCD;
    pe = rr + CL + ln;
    eo = pe + TRP + 1;
    addr = {b, r, c};
    rd_burst_len = 10'(len);
    init_end = 1'b1;
    rd_en = 1'b1;
    w = 0;
    do begin
      @(negedge sys_clk);
      w++;
    end while (!rd_ack && w < 20);
    chk("ack_seen", 32'(rd_ack), 1);
    if (!rd_ack) return;
    if (exp_wait > 0) chk("ack_wait", w, exp_wait);
    chk("act_cmd", rd_cmd, C_ACT);
    chk("act_ba", rd_ba, b);
    chk("act_row", rd_addr, r);
    addr = $urandom;
    rd_burst_len = 10'($urandom);
    if (!hold) rd_en = 1'b0;
    bad = 0;
    bd = 0;
    k = 0;
    for (int o = 1; o <= eo; o++) begin
      @(negedge sys_clk);
      ec = o == rr ? C_RD : o == rr + ln ? C_BST : o == pe ? C_PRE : C_NOP;
      if (rd_cmd !== ec || rd_ack !== 1'b0 || rd_end !== (o == eo) || rd_data_vld !== (o > rr + CL && o <= pe)) bad++;
      if (o == rr) begin
        chk("rd_ba", rd_ba, b);
        chk("rd_col", rd_addr, {4'b0000, c});
      end
      if (o == rr + ln) chk("bst_addr", rd_addr, {4'b0000, c});
      if (o == pe) chk("pre_addr", rd_addr, 13'h0400);
      if (rd_data_vld) begin
        if (rd_data !== memw(b, r, c + 9'(k))) bd++;
        k++;
      end
      if (o < eo) init_end = 1'($urandom);
    end
    init_end = 1'b1;
    chk("cmd_seq", bad, 0);
    chk("vld_cnt", k, ln);
    chk("data", bd, 0);
  endtask
  initial begin
    int bad, w;
    sys_rst = 1'b1;
    rd_en = 1'b1;
    init_end = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge sys_clk);
      if (rd_ack !== 1'b0) bad++;
    end
    chk("rst_noack", bad, 0);
    chk("rst_cmd", rd_cmd, C_NOP);
    chk("rst_ba", rd_ba, 2'b11);
    chk("rst_addr", rd_addr, 13'h1FFF);
    chk("rst_data", rd_data, 0);
    chk("rst_vld", 32'(rd_data_vld), 0);
    chk("rst_end", 32'(rd_end), 0);
    rd_en = 1'b0;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    burst(2'd1, 13'd1, 9'd3, 4, 1, 1'b0);
    @(negedge sys_clk);
    burst(2'($urandom), 13'($urandom), 9'($urandom), 0, 0, 1'b0);
    burst(2'($urandom), 13'($urandom), 9'($urandom), 700, 0, 1'b0);
    burst(2'd2, 13'h0ABC, 9'd510, 4, 0, 1'b0);
    rd_en = 1'b1;
    init_end = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge sys_clk);
      if (rd_cmd !== C_NOP || rd_ack !== 1'b0) bad++;
    end
    chk("no_init", bad, 0);
    burst(2'd3, 13'h1234, 9'd100, 5, 1, 1'b0);
    burst(2'd0, 13'h0777, 9'd20, 6, 0, 1'b1);
    burst(2'd2, 13'h1F00, 9'd300, 3, 2, 1'b0);
    addr = {2'd1, 13'h0042, 9'd7};
    rd_burst_len = 10'd8;
    rd_en = 1'b1;
    w = 0;
    do begin
      @(negedge sys_clk);
      w++;
    end while (!rd_ack && w < 20);
    chk("rst6_ack", 32'(rd_ack), 1);
    rd_en = 1'b0;
    repeat (1 + TRCD + 2) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    chk("abort_cmd", rd_cmd, C_NOP);
    chk("abort_vld", 32'(rd_data_vld), 0);
    chk("abort_ba", rd_ba, 2'b11);
    bad = 0;
    repeat (20) begin
      @(negedge sys_clk);
      if (rd_cmd !== C_NOP || rd_end !== 1'b0 || rd_ack !== 1'b0 || rd_data_vld !== 1'b0) bad++;
    end
    chk("abort_quiet", bad, 0);
    burst(2'd1, 13'h0042, 9'd7, 8, 1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge sys_clk);
      burst(2'($urandom), 13'($urandom), 9'($urandom),
            $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 20)), 0, 1'b0);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
